video_timing_gen: RTL and testbench

- Parametrised raster timing generator. It succeeds the fixed 640x480 counter/sync logic used ahead of the TMDS encoders.
- Produces pixel coordinates, DE, hsync and vsync for any CEA/VESA mode.
- Has a clock-enable, a configurable sync/DE pipeline delay to match downstream pixel-pipeline latency, and per-line/per-frame strobes.
- Sits between the pixel-clock domain and the three TMDS channel encoders; blue channel CD = {vsync,hsync}.

---
 rtl/video_timing_pkg.sv | 60 ++++++
 rtl/sync_delay.sv | 49 ++++
 rtl/video_timing_gen.sv | 202 ++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Purpose: shared constants and helpers for the raster timing generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Provides line/frame total helpers, sync window bounds, the colour-bar
// table and reference parameter sets for 640x480@60 and 1280x720@60.

package video_timing_pkg;

    // Total length of a line or frame from its four regions.
    function automatic int timing_total(input int active, input int fp,
                                        input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

    // First count inside the sync window.
    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // First count after the sync window (exclusive end).
    function automatic int sync_end(input int active, input int fp, input int sync_w);
        return active + fp + sync_w;
    endfunction

    localparam int PIPE_MAX  = 4;
    localparam int BAR_COUNT = 8;

    // Colour bars left to right, {R,G,B}:
    // white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [0:BAR_COUNT-1][23:0] COLOUR_BARS = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    // 640x480@60, 25.175 MHz pixel clock, both syncs used active-high here.
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_POL    = 1;
    localparam int VGA_V_POL    = 1;

    // 1280x720@60, 74.25 MHz pixel clock, positive syncs.
    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;
    localparam int HD720_H_POL    = 1;
    localparam int HD720_V_POL    = 1;

endpackage

// File: rtl/sync_delay.sv
// Purpose: WIDTH-bit, PIPE-deep shift register that advances only on ce.
// Latency: PIPE enabled cycles; PIPE=0 is a combinational pass-through.
// Backpressure: none; ce=0 freezes every stage.
//
// Ports: pixclk, rst (sync, active-high), ce (shift enable),
//        rst_val (value loaded into every stage on reset),
//        din (stage-0 input), dout (last stage).

module sync_delay #(
    parameter int WIDTH = 1,
    parameter int PIPE  = 1
) (
    input  logic             pixclk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (PIPE == 0) begin : g_pass
            // No register to clear, so reset forces the output directly;
            // this keeps the reset-time output values identical for all PIPE.
            assign dout = rst ? rst_val : din;

            logic unused_clk_ce;
            assign unused_clk_ce = &{1'b0, pixclk, ce};
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [PIPE];

            always_ff @(posedge pixclk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE; i++) begin
                        stage_q[i] <= rst_val;
                    end
                end else if (ce) begin
                    stage_q[0] <= din;
                    for (int i = 1; i < PIPE; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign dout = stage_q[PIPE-1];
        end
    endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Purpose: parametrised raster timing generator (coords, DE, syncs, strobes).
// Latency: x/y from registers with no delay; de/hsync/vsync/sol/sof/rgb PIPE enabled cycles later.
// Backpressure: none; ce=0 holds counters, delay line and pattern state.
//
// Ports: pixclk, rst (sync, active-high, wins over ce), ce (pixel enable),
//        x/y (undelayed counts), de/hsync/vsync/sol/sof (delayed by PIPE),
//        red/green/blue (colour bars aligned with de, zero in blanking).
// Optional build macro VIDEO_TIMING_PATTERN_EN enables the colour-bar pattern;
// without it red/green/blue are tied to zero.

module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int H_POL    = VGA_H_POL,
    parameter int V_POL    = VGA_V_POL,
    parameter int PIPE     = 1,
    parameter int CW       = 12
) (
    input  logic          pixclk,
    input  logic          rst,
    input  logic          ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          sol,
    output logic          sof,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue
);

    localparam int H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = sync_start(H_ACTIVE, H_FP);
    localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
    localparam int VS_START = sync_start(V_ACTIVE, V_FP);
    localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

    // ------------------------------------------------------------------
    // Elaboration-time legality checks
    // ------------------------------------------------------------------
    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
            $error("video_timing_gen: every active/porch/sync region must be >= 1");
        end
        if (PIPE < 0 || PIPE > PIPE_MAX) begin : g_bad_pipe
            $error("video_timing_gen: PIPE must be in 0..4");
        end
        if (CW < 1 || ((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
            $error("video_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    // Bounds as CW-bit constants so all compares are width-matched. Every
    // exclusive end is < TOTAL because the back porch is at least one count.
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
    localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
    localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
    localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);
    localparam logic          H_POL_B    = (H_POL != 0);
    localparam logic          V_POL_B    = (V_POL != 0);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          x_last;
    logic          y_last;

    assign x_last = (x_q == H_LAST_C);
    assign y_last = (y_q == V_LAST_C);

    always_ff @(posedge pixclk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (ce) begin
            if (x_last) begin
                x_q <= '0;
                y_q <= y_last ? '0 : (y_q + ONE_C);
            end else begin
                x_q <= x_q + ONE_C;
            end
        end
    end

    assign x = x_q;
    assign y = y_q;

    // ------------------------------------------------------------------
    // Raw timing decode (vsync depends on y only, so it switches with x==0)
    // ------------------------------------------------------------------
    logic de_r;
    logic hs_r;
    logic vs_r;
    logic sol_r;
    logic sof_r;

    assign de_r  = (x_q < H_ACT_C) && (y_q < V_ACT_C);
    assign hs_r  = (x_q >= HS_START_C) && (x_q < HS_END_C);
    assign vs_r  = (y_q >= VS_START_C) && (y_q < VS_END_C);
    assign sol_r = (x_q == '0);
    assign sof_r = sol_r && (y_q == '0);

    // ------------------------------------------------------------------
    // Delay line; syncs are carried as "asserted" flags and polarity is
    // applied at the output, so the all-zero reset value means "inactive".
    // ------------------------------------------------------------------
    logic [4:0] tim_d;

    sync_delay #(
        .WIDTH (5),
        .PIPE  (PIPE)
    ) u_tim_delay (
        .pixclk  (pixclk),
        .rst     (rst),
        .ce      (ce),
        .rst_val (5'b0),
        .din     ({de_r, hs_r, vs_r, sol_r, sof_r}),
        .dout    (tim_d)
    );

    assign de    = tim_d[4];
    assign hsync = tim_d[3] ? H_POL_B : ~H_POL_B;
    assign vsync = tim_d[2] ? V_POL_B : ~V_POL_B;
    assign sol   = tim_d[1];
    assign sof   = tim_d[0];

    // ------------------------------------------------------------------
    // Colour-bar pattern
    // ------------------------------------------------------------------
`ifdef VIDEO_TIMING_PATTERN_EN
    // Narrow actives still get one-pixel bars rather than a zero width.
    localparam int            BW      = (H_ACTIVE / BAR_COUNT < 1) ? 1 : (H_ACTIVE / BAR_COUNT);
    localparam logic [CW-1:0] BW_LAST = CW'(BW - 1);

    logic [CW-1:0] sub_q;
    logic [2:0]    bar_q;
    logic [23:0]   rgb_r;
    logic [23:0]   rgb_d;

    // bar_q/sub_q always describe the pixel at x_q: both are cleared on the
    // same edge x wraps. The last bar stops advancing so any remainder of
    // H_ACTIVE/8 is absorbed by it.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            sub_q <= '0;
            bar_q <= '0;
        end else if (ce) begin
            if (x_last) begin
                sub_q <= '0;
                bar_q <= '0;
            end else if (sub_q == BW_LAST && bar_q != 3'd7) begin
                sub_q <= '0;
                bar_q <= bar_q + 3'd1;
            end else begin
                sub_q <= sub_q + ONE_C;
            end
        end
    end

    assign rgb_r = de_r ? COLOUR_BARS[bar_q] : 24'h000000;

    sync_delay #(
        .WIDTH (24),
        .PIPE  (PIPE)
    ) u_rgb_delay (
        .pixclk  (pixclk),
        .rst     (rst),
        .ce      (ce),
        .rst_val (24'h000000),
        .din     (rgb_r),
        .dout    (rgb_d)
    );

    assign red   = rgb_d[23:16];
    assign green = rgb_d[15:8];
    assign blue  = rgb_d[7:0];
`else
    assign red   = 8'h00;
    assign green = 8'h00;
    assign blue  = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Purpose: directed self-checking bench for video_timing_gen.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
//
// Three instances share clock, reset and ce: a tiny 12x7 mode with
// active-low syncs at PIPE=0 and PIPE=3, and the default 800x525 mode at PIPE=1.

module tb_video_timing_gen;

    logic pixclk;
    logic rst;
    logic ce;

    // tiny mode, PIPE=0
    logic [3:0] x0, y0;
    logic       de0, hs0, vs0, sol0, sof0;
    logic [7:0] r0, g0, b0;
    // tiny mode, PIPE=3
    logic [3:0] x3, y3;
    logic       de3, hs3, vs3, sol3, sof3;
    logic [7:0] r3, g3, b3;
    // default 640x480 mode, PIPE=1
    logic [11:0] xh, yh;
    logic        deh, hsh, vsh, solh, sofh;
    logic [7:0]  rh, gh, bh;

    int vectors;
    int errors;
    int k;
    int de_cnt, hs_cnt, sol_cnt, sof_cnt, sof_exp;

    initial pixclk = 1'b0;
    always #5 pixclk = ~pixclk;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .PIPE(0), .CW(4)
    ) u_p0 (
        .pixclk(pixclk), .rst(rst), .ce(ce), .x(x0), .y(y0),
        .de(de0), .hsync(hs0), .vsync(vs0), .sol(sol0), .sof(sof0),
        .red(r0), .green(g0), .blue(b0)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(0), .V_POL(0), .PIPE(3), .CW(4)
    ) u_p3 (
        .pixclk(pixclk), .rst(rst), .ce(ce), .x(x3), .y(y3),
        .de(de3), .hsync(hs3), .vsync(vs3), .sol(sol3), .sof(sof3),
        .red(r3), .green(g3), .blue(b3)
    );

    video_timing_gen #(
        .PIPE(1)
    ) u_hd (
        .pixclk(pixclk), .rst(rst), .ce(ce), .x(xh), .y(yh),
        .de(deh), .hsync(hsh), .vsync(vsh), .sol(solh), .sof(sofh),
        .red(rh), .green(gh), .blue(bh)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge pixclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {de, hsync level, vsync level, sol, sof} of the tiny mode
    // (H 8/1/2/1 = 12, V 4/1/1/1 = 7, active-low syncs) for the raster
    // position reached after k enabled cycles; k<0 means reset values.
    function automatic logic [4:0] small_exp(input int kk);
        int xx;
        int yy;
        if (kk < 0) return 5'b01100;
        xx = kk % 12;
        yy = (kk / 12) % 7;
        return {(xx < 8) && (yy < 4), !((xx >= 9) && (xx < 11)), !(yy == 5),
                xx == 0, (xx == 0) && (yy == 0)};
    endfunction

    task automatic check_small(input int kk);
        chk("p0_x", {28'd0, x0}, kk % 12);
        chk("p0_y", {28'd0, y0}, (kk / 12) % 7);
        chk("p0_sig", {27'd0, de0, hs0, vs0, sol0, sof0}, {27'd0, small_exp(kk)});
        chk("p3_sig", {27'd0, de3, hs3, vs3, sol3, sof3}, {27'd0, small_exp(kk - 3)});
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        ce  = 1'b0;

        // Reset works without ce, and wins over ce.
        tick();
        tick();
        ce = 1'b1;
        tick();
        tick();
        chk("rst_p0_x", {28'd0, x0}, 0);
        chk("rst_p0_y", {28'd0, y0}, 0);
        chk("rst_p0_sig", {27'd0, de0, hs0, vs0, sol0, sof0}, 32'b01100);
        chk("rst_p3_sig", {27'd0, de3, hs3, vs3, sol3, sof3}, 32'b01100);
        chk("rst_hd_sig", {27'd0, deh, hsh, vsh, solh, sofh}, 32'b00000);
        chk("rst_hd_rgb", {8'd0, rh, gh, bh}, 0);
        chk("rst_p0_rgb", {8'd0, r0, g0, b0}, 0);

        // Release: first cycle presents (0,0); PIPE=0 strobes are immediate.
        rst = 1'b0;
        #1;
        k = 0;
        chk("first_p0_sig", {27'd0, de0, hs0, vs0, sol0, sof0}, 32'b11111);

        // Two full tiny frames with ce held high.
        de_cnt = 0; hs_cnt = 0; sol_cnt = 0; sof_cnt = 0;
        repeat (168) begin
            check_small(k);
            if (k < 84) begin
                de_cnt  += int'(de0);
                hs_cnt  += int'(!hs0);
                sol_cnt += int'(sol0);
                sof_cnt += int'(sof0);
            end
            if (k == 11) chk("p0_x_last", {28'd0, x0}, 11);
            if (k == 83) chk("p0_y_last", {28'd0, y0}, 6);
            tick();
            k++;
        end
        chk("frame_de_cnt", de_cnt, 32);
        chk("frame_hs_cnt", hs_cnt, 14);
        chk("frame_sol_cnt", sol_cnt, 7);
        chk("frame_sof_cnt", sof_cnt, 1);
        check_small(k);

        // ce roughly one cycle in three; outputs must hold across ce=0 and
        // strobes are counted once per enabled cycle.
        sof_cnt = 0;
        sof_exp = 0;
        repeat (600) begin
            ce = ($urandom_range(0, 2) == 0);
            tick();
            if (ce) begin
                k++;
                sof_cnt += int'(sof0);
                if (k % 84 == 0) sof_exp++;
            end
            check_small(k);
        end
        chk("gated_sof_cnt", sof_cnt, sof_exp);

        // Run to x=7,y=5 (inside vsync), then reset mid-frame.
        ce = 1'b1;
        while ((k % 84) != 67) begin
            tick();
            k++;
            check_small(k);
        end
        chk("pre_rst_p0_vs", {31'd0, vs0}, 0);
        chk("pre_rst_p3_vs", {31'd0, vs3}, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_p0_x", {28'd0, x0}, 0);
        chk("mid_rst_p0_y", {28'd0, y0}, 0);
        chk("mid_rst_p0_vs", {31'd0, vs0}, 1);
        chk("mid_rst_p3_sig", {27'd0, de3, hs3, vs3, sol3, sof3}, 32'b01100);
        rst = 1'b0;
        #1;
        k = 0;
        repeat (20) begin
            check_small(k);
            tick();
            k++;
        end

        // Default 800x525 mode: one line plus two cycles, PIPE=1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        k = 0;
        hs_cnt = 0;
        repeat (802) begin
            if (k >= 1 && k <= 800) hs_cnt += int'(hsh);
            if (k == 0)   chk("hd_sof_k0", {31'd0, sofh}, 0);
            if (k == 1)   chk("hd_sof_k1", {27'd0, deh, hsh, vsh, solh, sofh}, 32'b10011);
            if (k == 656) chk("hd_hs_656", {31'd0, hsh}, 0);
            if (k == 657) chk("hd_hs_657", {31'd0, hsh}, 1);
            if (k == 752) chk("hd_hs_752", {31'd0, hsh}, 1);
            if (k == 753) chk("hd_hs_753", {31'd0, hsh}, 0);
            if (k == 641) chk("hd_de_641", {31'd0, deh}, 0);
            if (k == 799) chk("hd_x_799", {20'd0, xh}, 799);
            if (k == 800) begin
                chk("hd_x_wrap", {20'd0, xh}, 0);
                chk("hd_y_inc", {20'd0, yh}, 1);
            end
`ifdef VIDEO_TIMING_PATTERN_EN
            if (k == 1)   chk("bar_white_x0", {8'd0, rh, gh, bh}, 32'hFFFFFF);
            if (k == 80)  chk("bar_white_x79", {8'd0, rh, gh, bh}, 32'hFFFFFF);
            if (k == 81)  chk("bar_yellow_x80", {8'd0, rh, gh, bh}, 32'hFFFF00);
            if (k == 241) chk("bar_green_x240", {8'd0, rh, gh, bh}, 32'h00FF00);
            if (k == 481) chk("bar_blue_x480", {8'd0, rh, gh, bh}, 32'h0000FF);
            if (k == 561) chk("bar_black_x560", {7'd0, deh, rh, gh, bh}, 32'h1000000);
            if (k == 641) chk("bar_blank_x640", {8'd0, rh, gh, bh}, 32'h000000);
`else
            if (k == 1)   chk("rgb_tied_x0", {8'd0, rh, gh, bh}, 32'h000000);
`endif
            tick();
            k++;
        end
        chk("hd_hs_line_cnt", hs_cnt, 96);
        chk("hd_vs_line0", {31'd0, vsh}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
